// File: rtl/mem_mon_pkg.sv
// ============================================================================
// Module      : mem_mon_pkg
// Description : Shared state and failure-cause encodings for mem_write_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } mon_state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_DATA    = 2'b01,
        FC_ADDR    = 2'b10,
        FC_TIMEOUT = 2'b11
    } fail_code_e;

endpackage : mem_mon_pkg

`default_nettype wire

// File: rtl/mem_mon_ign_match.sv
// ============================================================================
// Module      : mem_mon_ign_match
// Description : Combinational N_IGN-entry address matcher with per-entry valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_mon_ign_match #(
    parameter int ADDR_W = 32,
    parameter int N_IGN  = 2
) (
    input  logic [N_IGN-1:0][ADDR_W-1:0] i_tbl_addr,
    input  logic [N_IGN-1:0]             i_tbl_vld,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         o_hit
);

    logic [N_IGN-1:0] w_ent_hit;

    generate
        for (genvar g = 0; g < N_IGN; g++) begin : g_ent
            assign w_ent_hit[g] = i_tbl_vld[g] && (i_tbl_addr[g] == i_addr);
        end
    endgenerate

    assign o_hit = |w_ent_hit;

endmodule : mem_mon_ign_match

`default_nettype wire

// File: rtl/mem_write_monitor.sv
// ============================================================================
// Module      : mem_write_monitor
// Description : Checks data-memory writes in order against an expected table,
//               skipping ignored addresses. Optional timeout: MEM_MON_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_monitor
    import mem_mon_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int N_EXP       = 4,
    parameter int N_IGN       = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memwrite,
    input  logic [ADDR_W-1:0]            dataadr,
    input  logic [DATA_W-1:0]            writedata,
    input  logic                         exp_push,
    input  logic [ADDR_W-1:0]            exp_addr,
    input  logic [DATA_W-1:0]            exp_data,
    input  logic                         ign_push,
    input  logic [ADDR_W-1:0]            ign_addr,
    input  logic                         tbl_clr,
    input  logic                         start,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         exp_full,
    output logic [$clog2(N_EXP+1)-1:0]   match_cnt,
    output logic [1:0]                   fail_code,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data
);

    localparam int c_cnt_w = $clog2(N_EXP + 1);
    localparam int c_ign_w = $clog2(N_IGN + 1);
`ifdef MEM_MON_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
`endif

    mon_state_e                  r_state;
    logic [c_cnt_w-1:0]          r_exp_num;
    logic [c_cnt_w-1:0]          r_match_cnt;
    logic [c_ign_w-1:0]          r_ign_num;
    logic [ADDR_W-1:0]           r_exp_addr [N_EXP];
    logic [DATA_W-1:0]           r_exp_data [N_EXP];
    logic [N_IGN-1:0][ADDR_W-1:0] r_ign_addr;
    logic                        r_pass;
    logic                        r_fail;
    fail_code_e                  r_fail_code;
    logic [ADDR_W-1:0]           r_fail_addr;
    logic [DATA_W-1:0]           r_fail_data;
`ifdef MEM_MON_TIMEOUT_EN
    logic [c_tmo_w-1:0]          r_tmo_cnt;
    logic                        w_wr_ends;
`endif

    logic [N_IGN-1:0]            w_ign_vld;
    logic [ADDR_W-1:0]           w_cur_addr;
    logic [DATA_W-1:0]           w_cur_data;
    logic                        w_addr_hit;
    logic                        w_data_hit;
    logic                        w_last;
    logic                        w_ign_hit;
    logic                        w_tbl_open;
    logic                        w_start_ok;

    generate
        for (genvar g = 0; g < N_IGN; g++) begin : g_ign_vld
            assign w_ign_vld[g] = (c_ign_w'(g) < r_ign_num);
        end
    endgenerate

    mem_mon_ign_match #(
        .ADDR_W (ADDR_W),
        .N_IGN  (N_IGN)
    ) u_ign_match (
        .i_tbl_addr (r_ign_addr),
        .i_tbl_vld  (w_ign_vld),
        .i_addr     (dataadr),
        .o_hit      (w_ign_hit)
    );

    // Only the entry at match_cnt is eligible: matching is strictly in order.
    always_comb begin
        w_cur_addr = '0;
        w_cur_data = '0;
        for (int i = 0; i < N_EXP; i++) begin
            if (c_cnt_w'(i) == r_match_cnt) begin
                w_cur_addr = r_exp_addr[i];
                w_cur_data = r_exp_data[i];
            end
        end
    end

    assign w_addr_hit = (dataadr == w_cur_addr);
    assign w_data_hit = (writedata == w_cur_data);
    assign w_last     = ((r_match_cnt + 1'b1) == r_exp_num);
    assign w_tbl_open = (r_state != ST_RUN);
    assign w_start_ok = start && (r_exp_num != '0);
    assign exp_full   = (r_exp_num == c_cnt_w'(N_EXP));

`ifdef MEM_MON_TIMEOUT_EN
    // A write that settles the run outranks a coincident timeout.
    assign w_wr_ends = memwrite && (w_addr_hit ? (!w_data_hit || w_last) : !w_ign_hit);
`endif

    // Table payload storage carries no reset; occupancy counters qualify it.
    always_ff @(posedge clk) begin
        if (w_tbl_open && !tbl_clr) begin
            for (int i = 0; i < N_EXP; i++) begin
                if (exp_push && (c_cnt_w'(i) == r_exp_num)) begin
                    r_exp_addr[i] <= exp_addr;
                    r_exp_data[i] <= exp_data;
                end
            end
            for (int i = 0; i < N_IGN; i++) begin
                if (ign_push && (c_ign_w'(i) == r_ign_num)) begin
                    r_ign_addr[i] <= ign_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_exp_num   <= '0;
            r_ign_num   <= '0;
            r_match_cnt <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= FC_NONE;
            r_fail_addr <= '0;
            r_fail_data <= '0;
`ifdef MEM_MON_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            if (w_tbl_open) begin
                if (tbl_clr) begin
                    r_exp_num <= '0;
                    r_ign_num <= '0;
                end else begin
                    if (exp_push && !exp_full) begin
                        r_exp_num <= r_exp_num + 1'b1;
                    end
                    if (ign_push && (r_ign_num != c_ign_w'(N_IGN))) begin
                        r_ign_num <= r_ign_num + 1'b1;
                    end
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (start) begin
                        r_match_cnt <= '0;
                        r_fail_code <= FC_NONE;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
`ifdef MEM_MON_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end else begin
                        if (memwrite) begin
                            if (w_addr_hit && w_data_hit) begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                                if (w_last) begin
                                    r_state <= ST_PASS;
                                    r_pass  <= 1'b1;
                                end
                            end else if (w_addr_hit || !w_ign_hit) begin
                                r_state     <= ST_FAIL;
                                r_fail      <= 1'b1;
                                r_fail_code <= w_addr_hit ? FC_DATA : FC_ADDR;
                                r_fail_addr <= dataadr;
                                r_fail_data <= writedata;
                            end
                        end
`ifdef MEM_MON_TIMEOUT_EN
                        if (!w_wr_ends) begin
                            if (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYC - 1)) begin
                                r_state     <= ST_FAIL;
                                r_fail      <= 1'b1;
                                r_fail_code <= FC_TIMEOUT;
                                r_fail_addr <= '0;
                                r_fail_data <= '0;
                            end else begin
                                r_tmo_cnt <= r_tmo_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                default: begin
                    if (w_start_ok) begin
                        r_state     <= ST_RUN;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_match_cnt <= '0;
                        r_fail_code <= FC_NONE;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
`ifdef MEM_MON_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign done      = r_pass | r_fail;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign match_cnt = r_match_cnt;
    assign fail_code = r_fail_code;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

endmodule : mem_write_monitor

`default_nettype wire

// File: tb/tb_mem_write_monitor.sv
// ============================================================================
// Module      : tb_mem_write_monitor
// Description : Directed plus randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_write_monitor;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NE  = 4;
    localparam int NI  = 2;
    localparam int TMO = 20;
    localparam int CW  = $clog2(NE + 1);

    logic          clk;
    logic          reset;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          exp_push;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          ign_push;
    logic [AW-1:0] ign_addr;
    logic          tbl_clr;
    logic          start;
    logic          done;
    logic          pass;
    logic          fail;
    logic          exp_full;
    logic [CW-1:0] match_cnt;
    logic [1:0]    fail_code;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    mem_write_monitor #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .N_EXP       (NE),
        .N_IGN       (NI),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .exp_push  (exp_push),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .ign_push  (ign_push),
        .ign_addr  (ign_addr),
        .tbl_clr   (tbl_clr),
        .start     (start),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .exp_full  (exp_full),
        .match_cnt (match_cnt),
        .fail_code (fail_code),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: tables as queues, run outcome as simple flags.
    logic [AW-1:0] m_ea[$];
    logic [DW-1:0] m_ed[$];
    logic [AW-1:0] m_ign[$];
    bit            m_run, m_pass, m_fail;
    int            m_match, m_tmo;
    logic [1:0]    m_code;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fdata;

    task automatic model_reset();
        m_ea.delete(); m_ed.delete(); m_ign.delete();
        m_run = 0; m_pass = 0; m_fail = 0; m_match = 0; m_tmo = 0;
        m_code = 2'b00; m_faddr = '0; m_fdata = '0;
    endtask

    function automatic bit in_ign(input logic [AW-1:0] a);
        foreach (m_ign[i]) if (m_ign[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_fail(input logic [1:0] code, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_run = 0; m_fail = 1; m_code = code; m_faddr = a; m_fdata = d;
    endtask

    task automatic model_edge();
        bit go;
        if (!m_run) begin
            go = start && (m_ea.size() > 0);
            if (tbl_clr) begin
                m_ea.delete(); m_ed.delete(); m_ign.delete();
            end else begin
                if (exp_push && m_ea.size() < NE) begin
                    m_ea.push_back(exp_addr);
                    m_ed.push_back(exp_data);
                end
                if (ign_push && m_ign.size() < NI) m_ign.push_back(ign_addr);
            end
            if (go) begin
                m_run = 1; m_pass = 0; m_fail = 0; m_match = 0; m_tmo = 0;
                m_code = 2'b00; m_faddr = '0; m_fdata = '0;
            end
        end else begin
            if (memwrite) begin
                if (dataadr == m_ea[m_match]) begin
                    if (writedata == m_ed[m_match]) begin
                        m_match++;
                        if (m_match == m_ea.size()) begin
                            m_run = 0; m_pass = 1;
                        end
                    end else begin
                        model_fail(2'b01, dataadr, writedata);
                    end
                end else if (!in_ign(dataadr)) begin
                    model_fail(2'b10, dataadr, writedata);
                end
            end
`ifdef MEM_MON_TIMEOUT_EN
            if (m_run) begin
                m_tmo++;
                if (m_tmo == TMO) model_fail(2'b11, '0, '0);
            end
`endif
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".done"},      done,      m_pass | m_fail);
        check({ph, ".pass"},      pass,      m_pass);
        check({ph, ".fail"},      fail,      m_fail);
        check({ph, ".exp_full"},  exp_full,  m_ea.size() == NE);
        check({ph, ".match_cnt"}, match_cnt, m_match);
        check({ph, ".fail_code"}, fail_code, m_code);
        check({ph, ".fail_addr"}, fail_addr, m_faddr);
        check({ph, ".fail_data"}, fail_data, m_fdata);
    endtask

    task automatic idle_inputs();
        memwrite = 0; exp_push = 0; ign_push = 0; tbl_clr = 0; start = 0;
    endtask

    // One clock: model advances with the inputs the DUT is about to sample.
    task automatic cyc(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ph);
        idle_inputs();
    endtask

    task automatic do_push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_push = 1; exp_addr = a; exp_data = d; cyc("push_exp");
    endtask

    task automatic do_push_ign(input logic [AW-1:0] a);
        ign_push = 1; ign_addr = a; cyc("push_ign");
    endtask

    task automatic do_clr();
        tbl_clr = 1; cyc("clr");
    endtask

    task automatic do_start();
        start = 1; cyc("start");
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        memwrite = 1; dataadr = a; writedata = d; cyc("write");
    endtask

    // Asserts reset between edges, holds it across one edge, releases between edges.
    task automatic do_reset();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        dataadr = '0; writedata = '0; exp_addr = '0; exp_data = '0; ign_addr = '0;
        model_reset();
        #1;
        check_all("por");
        #12;
        reset = 1'b1;

        // Ignored write then matching write passes
        do_clr();
        do_push_exp(32'd84, 32'd241);
        do_push_ign(32'd80);
        do_start();
        do_write(32'd80, 32'd7);
        check("s1_pre_done", done, 1'b0);
        do_write(32'd84, 32'd241);
        check("s1_pass", pass, 1'b1);
        check("s1_done", done, 1'b1);
        check("s1_match", match_cnt, 1);

        // Data mismatch
        do_start();
        do_write(32'd84, 32'd240);
        check("s2_fail", fail, 1'b1);
        check("s2_code", fail_code, 2'b01);
        check("s2_addr", fail_addr, 32'd84);
        check("s2_data", fail_data, 32'd240);

        // Unknown address, then restart clears failure
        do_start();
        do_write(32'd88, 32'd5);
        check("s3_code", fail_code, 2'b10);
        check("s3_addr", fail_addr, 32'd88);
        do_start();
        check("s3_restart_fail", fail, 1'b0);

        // Reset mid-run, then start with empty tables is ignored
        do_reset();
        do_start();
        do_write(32'd88, 32'd5);
        check("s4_no_fail", fail, 1'b0);

        // Out-of-order write fails on address
        do_push_exp(32'd84, 32'd1);
        do_push_exp(32'd88, 32'd2);
        do_push_exp(32'd92, 32'd3);
        do_start();
        do_write(32'd88, 32'd2);
        check("s5_code", fail_code, 2'b10);
        check("s5_match", match_cnt, 0);

        // Overfill expected table: last push dropped
        do_clr();
        for (int i = 0; i <= NE; i++) do_push_exp(32'(i * 4), 32'(i + 10));
        check("s6_full", exp_full, 1'b1);
        do_start();
        for (int i = 0; i < NE; i++) do_write(32'(i * 4), 32'(i + 10));
        check("s6_pass", pass, 1'b1);
        check("s6_match", match_cnt, NE);

        // Idle run: timeout exactly TMO cycles after entry, or no timeout at all
        do_start();
        for (int i = 1; i < TMO; i++) cyc("tmo_wait");
`ifdef MEM_MON_TIMEOUT_EN
        check("s7_not_yet", fail, 1'b0);
        cyc("tmo_hit");
        check("s7_fail", fail, 1'b1);
        check("s7_code", fail_code, 2'b11);
        check("s7_addr", fail_addr, 32'd0);
`else
        for (int i = 0; i < 2 * TMO; i++) cyc("tmo_none");
        check("s7_still_run", done, 1'b0);
`endif
        do_reset();

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                if (!m_run) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: begin
                            exp_push = 1;
                            exp_addr = 32'($urandom_range(0, 7) * 4);
                            exp_data = 32'($urandom_range(0, 3));
                        end
                        4: begin
                            ign_push = 1;
                            ign_addr = 32'($urandom_range(0, 7) * 4);
                        end
                        5: tbl_clr = ($urandom_range(0, 3) == 0);
                        default: start = 1;
                    endcase
                end else begin
                    if ($urandom_range(0, 9) < 6) begin
                        memwrite = 1;
                        if ($urandom_range(0, 1) == 1) begin
                            dataadr   = m_ea[m_match];
                            writedata = ($urandom_range(0, 9) < 8) ? m_ed[m_match]
                                                                   : m_ed[m_match] ^ 32'h1;
                        end else begin
                            dataadr   = 32'($urandom_range(0, 7) * 4);
                            writedata = 32'($urandom_range(0, 3));
                        end
                    end
                    if ($urandom_range(0, 9) == 0) begin
                        exp_push = 1; ign_push = 1;
                        tbl_clr  = ($urandom_range(0, 1) == 1);
                        exp_addr = 32'($urandom_range(0, 7) * 4);
                        ign_addr = 32'($urandom_range(0, 7) * 4);
                    end
                end
                cyc("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_write_monitor

`default_nettype wire
